// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: architectural PC register with fetch handshake, execute hold and redirect resolution.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        addr_fault,
  output logic        fetch_fault
);
  localparam logic [1:0] BOOT = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALT = 2'd3;
  localparam logic [7:0] LAST_WAIT = 8'(IMEM_TIMEOUT - 1);
  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic [31:0] next_pc;
  assign imem_req = state == FETCH;
  assign instr_valid = state == EXEC;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  always_comb
    next_pc = jr ? {jr_addr[31:2], 2'b00} :
              jump ? {pc_plus4[31:28], jump_target, 2'b00} :
              branch_taken ? pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00} :
              pc_plus4;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      retired <= '0;
      wait_cnt <= '0;
      addr_fault <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH:
          if (imem_ready) begin
            state <= EXEC;
            wait_cnt <= '0;
          end else if (wait_cnt == LAST_WAIT) begin
            fetch_fault <= 1'b1;
            state <= HALT;
          end else wait_cnt <= wait_cnt + 8'd1;
        EXEC:
          if (!stall) begin
            pc <= next_pc;
            retired <= retired + 32'd1;
            state <= FETCH;
            if (jr && |jr_addr[1:0]) addr_fault <= 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed redirect sequence with a queue scoreboard checked at each EXEC entry and exit.
module tb_pc_fetch_sequencer;
  logic clk, reset_n, imem_ready, stall, branch_taken, jump, jr;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] jr_addr;
  logic imem_req, instr_valid, addr_fault, fetch_fault;
  logic [31:0] imem_addr, pc, pc_plus4, retired;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] sb_pc[$];
  int sb_len[$];
  int cur_len = 0, exp_len = 0;
  logic in_exec = 0;
  logic [31:0] e_pc;

  pc_fetch_sequencer #(.RESET_PC(32'h100), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .retired(retired), .addr_fault(addr_fault), .fetch_fault(fetch_fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      in_exec = 0;
      cur_len = 0;
    end else if (instr_valid && !in_exec) begin
      in_exec = 1;
      cur_len = 1;
      if (sb_pc.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got pc %h expected no instruction", pc);
        exp_len = 0;
      end else begin
        e_pc = sb_pc.pop_front();
        exp_len = sb_len.pop_front();
        chk("exec_pc", pc, e_pc);
        chk("exec_pc_plus4", pc_plus4, e_pc + 32'd4);
        chk("exec_req_low", {31'd0, imem_req}, 32'd0);
      end
    end else if (instr_valid) cur_len++;
    else if (in_exec) begin
      in_exec = 0;
      chk("exec_len", cur_len, exp_len);
    end
  end

  task automatic issue(input logic [31:0] exp_pc, input int stalls, input logic j_r,
                       input logic [31:0] ja, input logic jp, input logic [25:0] jt,
                       input logic bt, input logic [15:0] bo);
    int n = 0;
    sb_pc.push_back(exp_pc);
    sb_len.push_back(stalls + 1);
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_wait: got no instr_valid expected valid for pc %h", exp_pc);
      return;
    end
    jr = j_r; jr_addr = ja; jump = jp; jump_target = jt; branch_taken = bt; branch_offset = bo;
    stall = stalls > 0;
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      if (i == stalls - 1) stall = 0;
    end
    @(negedge clk);
    jr = 0; jr_addr = 0; jump = 0; jump_target = 0; branch_taken = 0; branch_offset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1; imem_ready = 1; stall = 0; branch_taken = 0; branch_offset = 0;
    jump = 0; jump_target = 0; jr = 0; jr_addr = 0;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_faults", {30'd0, addr_fault, fetch_fault}, 32'd0);
    reset_n = 1;
    #1 chk("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("boot_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("boot_fetch_addr", imem_addr, 32'h100);
    issue(32'h100, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h104, 2, 0, 0, 0, 0, 0, 0);
    issue(32'h108, 0, 0, 0, 0, 0, 0, 0);
    chk("retired_3", retired, 32'd3);
    issue(32'h10C, 0, 1, 32'h200, 0, 0, 0, 0);
    issue(32'h200, 0, 0, 0, 0, 0, 1, 16'hFFFF);
    issue(32'h200, 0, 0, 0, 0, 0, 1, 16'h0010);
    issue(32'h244, 0, 1, 32'h4000_0000, 0, 0, 0, 0);
    chk("addr_fault_clear", {31'd0, addr_fault}, 32'd0);
    issue(32'h4000_0000, 0, 1, 32'h1003, 1, 26'h3, 1, 16'h0010);
    chk("addr_fault_set", {31'd0, addr_fault}, 32'd1);
    issue(32'h1000, 0, 1, 32'h4000_0000, 0, 0, 0, 0);
    issue(32'h4000_0000, 0, 0, 0, 1, 26'h3, 0, 0);
    issue(32'h4000_000C, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    issue(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    imem_ready = 0;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    repeat (15) @(negedge clk);
    chk("fetch16_req", {31'd0, imem_req}, 32'd1);
    chk("fetch16_fault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    chk("timeout_fault", {31'd0, fetch_fault}, 32'd1);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc", pc, 32'h0);
    chk("halt_retired", retired, 32'd12);
    imem_ready = 1;
    repeat (3) @(negedge clk);
    chk("halt_stays_req", {31'd0, imem_req}, 32'd0);
    chk("halt_stays_pc", pc, 32'h0);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    issue(32'h100, 0, 0, 0, 0, 0, 0, 0);
    sb_pc.push_back(32'h104);
    sb_len.push_back(1);
    for (int n = 0; n < 50 && !instr_valid; n++) @(negedge clk);
    chk("pre_abort_valid", {31'd0, instr_valid}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("abort_valid", {31'd0, instr_valid}, 32'd0);
    chk("abort_pc", pc, 32'h100);
    chk("abort_retired", retired, 32'd0);
    chk("abort_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 0;
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb_pc.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
